pe_stream_feeder: RTL

- Bus-side transmitter for the PE load interfaces: drives `start_feature_load`/`start_weight_load`, `feature_in`/`weight_in` and their enables into one PE stream, under PE FIFO backpressure.
- Fetches words from a global-buffer read port with 1-cycle read latency and pushes them to the PE.
- One instance per stream (fmap or weight). Replaces bench-task stimulus in PE-array integration.

---
 rtl/pe_stream_feeder.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/pe_stream_feeder.sv
// pe_stream_feeder
//   Streams a block of words from a global-buffer read port (1-cycle read
//   latency) into one PE load interface (fmap or weight), honouring the PE
//   FIFO full flag. Reads are prefetched into a 2-entry skid buffer so the
//   stream sustains one word per cycle without backpressure.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   start             transfer request pulse, accepted only when idle
//   base_addr         first buffer address (latched on accepted start)
//   length            number of words (latched on accepted start)
//   full_column       forwarded on load_full_cloumn (latched on accepted start)
//   gb_rd_en/addr     buffer read strobe and address
//   gb_rd_data        buffer read data, valid the cycle after gb_rd_en
//   start_load        one-cycle pulse to the PE start_*_load input
//   load_full_cloumn  to the PE load_full_cloumn input
//   data_out/_en      PE data word and its enable
//   pe_fifo_full      PE FIFO full flag (backpressure)
//   busy              transfer in progress
//   done              one-cycle pulse after the last word is transferred
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; transfer parameters latched on start
// START  | start_load pulse to the PE
// STREAM | prefetch reads and push words while the PE FIFO has room
// DONE   | done pulse, back to IDLE

module pe_stream_feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    input  logic                  full_column,
    output logic                  gb_rd_en,
    output logic [ADDR_WIDTH-1:0] gb_rd_addr,
    input  logic [DATA_WIDTH-1:0] gb_rd_data,
    output logic                  start_load,
    output logic                  load_full_cloumn,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_en,
    input  logic                  pe_fifo_full,
    output logic                  busy,
    output logic                  done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_START  = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic                  full_col_q;
    logic [LEN_WIDTH-1:0]  reads_issued;
    logic [LEN_WIDTH-1:0]  words_sent;
    logic                  rd_pending;
    logic [DATA_WIDTH-1:0] skid0;
    logic [DATA_WIDTH-1:0] skid1;
    logic [1:0]            skid_count;

    logic       accept;
    logic       head_valid;
    logic       pop;
    logic       capture;
    logic [1:0] occ;
    logic       last_pop;

    assign accept     = (state == S_IDLE) && start;
    assign head_valid = (skid_count != 2'd0);
    assign pop        = head_valid && !pe_fifo_full;
    assign capture    = rd_pending;

    // Words already read but not yet handed to the PE, including the one in flight.
    assign occ = skid_count + {1'b0, rd_pending};

    // occ never exceeds 2, so "occ<2 or a pop this cycle" covers the full-with-pop case.
    assign gb_rd_en   = (state == S_STREAM) && (reads_issued < len_q) &&
                        ((occ < 2'd2) || pop);
    assign gb_rd_addr = base_q + ADDR_WIDTH'(reads_issued);

    assign last_pop = pop && (words_sent == (len_q - LEN_WIDTH'(1)));

    assign data_out_en      = pop;
    assign data_out         = head_valid ? skid0 : '0;
    assign start_load       = (state == S_START);
    assign done             = (state == S_DONE);
    assign busy             = (state != S_IDLE);
    assign load_full_cloumn = full_col_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            base_q     <= '0;
            len_q      <= '0;
            full_col_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_q     <= base_addr;
                        len_q      <= length;
                        full_col_q <= full_column;
                        state      <= S_START;
                    end
                end
                S_START: begin
                    state <= (len_q != '0) ? S_STREAM : S_DONE;
                end
                S_STREAM: begin
                    if (last_pop) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reads_issued <= '0;
            words_sent   <= '0;
            rd_pending   <= 1'b0;
        end else begin
            rd_pending <= gb_rd_en;
            if (accept) begin
                reads_issued <= '0;
                words_sent   <= '0;
            end else begin
                if (gb_rd_en) begin
                    reads_issued <= reads_issued + LEN_WIDTH'(1);
                end
                if (pop) begin
                    words_sent <= words_sent + LEN_WIDTH'(1);
                end
            end
        end
    end

    // skid0 is always the head; a pop shifts skid1 forward, a capture fills the tail.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid0      <= '0;
            skid1      <= '0;
            skid_count <= 2'd0;
        end else begin
            case (skid_count)
                2'd0: begin
                    if (capture) begin
                        skid0      <= gb_rd_data;
                        skid_count <= 2'd1;
                    end
                end
                2'd1: begin
                    case ({pop, capture})
                        2'b11: skid0 <= gb_rd_data;
                        2'b10: skid_count <= 2'd0;
                        2'b01: begin
                            skid1      <= gb_rd_data;
                            skid_count <= 2'd2;
                        end
                        default: ;
                    endcase
                end
                2'd2: begin
                    if (pop) begin
                        skid0 <= skid1;
                        if (capture) begin
                            skid1 <= gb_rd_data;
                        end else begin
                            skid_count <= 2'd1;
                        end
                    end
                end
                default: begin
                    skid_count <= 2'd0;
                end
            endcase
        end
    end

endmodule
